// File: rtl/onehot_encode_pkg.sv
// onehot_encode_pkg: shared result type and one-hot validity helper for the encoder pipe
package onehot_encode_pkg;
    localparam int ENC_N = 2;
    localparam int MAX_W = 64;
    typedef struct packed {
        logic             en;
        logic [ENC_N-1:0] a;
        logic             err;
    } enc_result_t;
    function automatic logic is_onehot_or_zero(input logic [MAX_W-1:0] w);
        return (w & (w - MAX_W'(1))) == '0;
    endfunction
endpackage

// File: rtl/prio_encode.sv
// prio_encode: combinational 2^N -> {en, a, err}; a tracks the highest set bit
module prio_encode
    import onehot_encode_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [2**N-1:0] y,
    output logic            en,
    output logic [N-1:0]    a,
    output logic            err
);
    always_comb begin
        en  = |y;
        a   = '0;
        for (int i = 0; i < 2**N; i++) a = y[i] ? N'(i) : a;
        err = !is_onehot_or_zero(MAX_W'(y));
    end
endmodule

// File: rtl/onehot_encode_pipe.sv
// onehot_encode_pipe: two-stage valid/ready one-hot-to-binary encoder with saturating error counter
module onehot_encode_pipe
    import onehot_encode_pkg::*;
#(
    parameter int N     = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2**N-1:0]  y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             en,
    output logic [N-1:0]     a,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);
    logic            s1_valid;
    logic [2**N-1:0] s1_y;
    logic            s1_ready, s2_ready, in_fire, s2_load;
    logic            enc_en, enc_err;
    logic [N-1:0]    enc_a;

    assign s2_ready = !out_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign in_fire  = in_valid && s1_ready;
    assign s2_load  = s1_valid && s2_ready;

    prio_encode #(.N(N)) u_enc (
        .y   (s1_y),
        .en  (enc_en),
        .a   (enc_a),
        .err (enc_err)
    );

    // out_valid doubles as the S2 valid bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_y      <= '0;
            out_valid <= 1'b0;
            en        <= 1'b0;
            a         <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s2_ready);
            if (in_fire) s1_y <= y;
            if (s2_ready) out_valid <= s1_valid;
            if (s2_load) begin
                en  <= enc_en;
                a   <= enc_a;
                err <= enc_err;
            end
            if (s2_load && enc_err && !(&err_count)) err_count <= err_count + CNT_W'(1);
        end
    end
endmodule
